// File: rtl/core_reset_done_ctrl.sv
// Multi-core reset sequencer: lock-qualified staggered release,
// sticky per-core done collection and run-cycle accounting.
module core_reset_done_ctrl #(
  parameter int NUM_CORES      = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int RST_PIPE_DEPTH = 6,
  parameter int STAGGER_CYCLES = 4,
  parameter int LOCK_WAIT      = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_locked,
  input  logic [NUM_CORES-1:0] i_core_done,
  input  logic                 i_restart,
  output logic [NUM_CORES-1:0] o_core_reset,
  output logic [NUM_CORES-1:0] o_done_mask,
  output logic                 o_done_all,
  output logic [CNT_WIDTH-1:0] o_run_cycles,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_LOCK_WAIT = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  localparam int REL_LAST = (NUM_CORES - 1) * STAGGER_CYCLES;
  localparam int RW = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;
  localparam int WW = $clog2(LOCK_WAIT + 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_int;
  logic                   lock_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= '1;
    else       rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_int = rst_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) lock_sync_q <= '0;
    else         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], i_locked};
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  state_e                 state_q, state_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [RW-1:0]          rel_cnt_q, rel_cnt_d;
  logic [NUM_CORES-1:0]   done_r_q, done_r_d;
  logic [NUM_CORES-1:0]   mask_q, mask_d;
  logic                   done_all_q, done_all_d;
  logic [CNT_WIDTH-1:0]   run_q, run_d;
  logic [NUM_CORES-1:0]   rel;
  logic                   lw_entry;
  logic                   clr_entry;

  logic [RST_PIPE_DEPTH-1:0][NUM_CORES-1:0] pipe_q;

  always_comb begin
    rel = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (state_q == S_RUN || state_q == S_DONE)
        rel[k] = 1'b1;
      else if (state_q == S_RELEASE)
        rel[k] = int'(rel_cnt_q) >= k * STAGGER_CYCLES;
    end
  end

  // Preset asynchronously so cores enter reset without a running clock.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      pipe_q <= '1;
    end else begin
      pipe_q[0] <= ~rel;
      for (int i = 1; i < RST_PIPE_DEPTH; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign o_core_reset = pipe_q[RST_PIPE_DEPTH-1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HOLD:      if (lock_s) state_d = S_LOCK_WAIT;
      S_LOCK_WAIT: if (int'(wait_q) >= LOCK_WAIT - 1) state_d = S_RELEASE;
      S_RELEASE:   if (int'(rel_cnt_q) + 1 >= REL_LAST) state_d = S_RUN;
      S_RUN: begin
        if (i_restart)       state_d = S_LOCK_WAIT;
        else if (done_all_q) state_d = S_DONE;
      end
      S_DONE:      if (i_restart) state_d = S_LOCK_WAIT;
      default:     state_d = S_HOLD;
    endcase
    if (!lock_s && state_q != S_HOLD) state_d = S_HOLD;

    lw_entry  = (state_d == S_LOCK_WAIT) && (state_q != S_LOCK_WAIT);
    clr_entry = (state_d != state_q) &&
                (state_d == S_HOLD || state_d == S_LOCK_WAIT);

    wait_d    = (state_q == S_LOCK_WAIT) ? wait_q + 1'b1 : '0;
    rel_cnt_d = (state_q == S_RELEASE) ? rel_cnt_q + 1'b1 : '0;

    run_d = run_q;
    if (lw_entry)
      run_d = '0;
    else if ((state_q == S_RELEASE || state_q == S_RUN) && run_q != '1)
      run_d = run_q + 1'b1;

    done_r_d   = i_core_done;
    mask_d     = mask_q | (done_r_q & ~o_core_reset);
    done_all_d = &mask_q;
    if (clr_entry) begin
      mask_d     = '0;
      done_all_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q    <= S_HOLD;
      wait_q     <= '0;
      rel_cnt_q  <= '0;
      done_r_q   <= '0;
      mask_q     <= '0;
      done_all_q <= 1'b0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rel_cnt_q  <= rel_cnt_d;
      done_r_q   <= done_r_d;
      mask_q     <= mask_d;
      done_all_q <= done_all_d;
      run_q      <= run_d;
    end
  end

  assign o_done_mask  = mask_q;
  assign o_done_all   = done_all_q;
  assign o_run_cycles = run_q;
  assign o_state      = state_q;

endmodule

// File: doc/core_reset_done_ctrl.md
CORE_RESET_DONE_CTRL -- requirements
Module: core_reset_done_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_CORES, 4: cores served; range 1..64.
- SYNC_STAGES, 2: synchronizer flops; minimum 2.
- RST_PIPE_DEPTH, 6: per-core reset pipeline registers; minimum 1.
- STAGGER_CYCLES, 4: spacing between successive core releases; 0 means simultaneous release.
- LOCK_WAIT, 16: settle cycles after lock; minimum 1.
- CNT_WIDTH, 32: run-cycle counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high.
- i_locked, in, 1: MMCM lock; asynchronous to clk.
- i_core_done, in, NUM_CORES: per-core done level/pulse.
- i_restart, in, 1: synchronous rerun request.
- o_core_reset, out, NUM_CORES: active-high per-core synchronous reset.
- o_done_mask, out, NUM_CORES: sticky per-core done.
- o_done_all, out, 1: all cores done; drives LED.
- o_run_cycles, out, CNT_WIDTH: cycles from RELEASE entry.
- o_state, out, 3: FSM state encoding.

Function
REQ-003 reset SHALL pass through a SYNC_STAGES-flop synchronizer: asynchronous assertion, deassertion on clk; the output is rst_int.
REQ-004 i_locked SHALL pass through a SYNC_STAGES-flop synchronizer, cleared by rst_int; the output is lock_s.
REQ-005 FSM states and encoding: HOLD=0, LOCK_WAIT=1, RELEASE=2, RUN=3, DONE=4.
REQ-006 HOLD SHALL go to LOCK_WAIT when lock_s=1.
REQ-007 LOCK_WAIT SHALL count LOCK_WAIT cycles, then go to RELEASE.
REQ-008 RELEASE SHALL run release counter r from 0, one increment per cycle.
REQ-009 RELEASE SHALL go to RUN in the cycle r=(NUM_CORES-1)*STAGGER_CYCLES.
REQ-010 RUN SHALL go to DONE when o_done_all=1.
REQ-011 lock_s=0 in any state other than HOLD SHALL force HOLD next cycle; this has priority over every other transition.
REQ-012 i_restart in RUN or DONE SHALL force LOCK_WAIT next cycle; it is ignored in the other states and loses to lock loss.
REQ-013 Release request rel[k] SHALL be 1 in RELEASE when r>=k*STAGGER_CYCLES, and SHALL stay 1 in RUN and DONE.
REQ-014 rel[k] SHALL be 0 in HOLD and LOCK_WAIT.
REQ-015 o_core_reset[k] SHALL be ~rel[k] delayed by exactly RST_PIPE_DEPTH registers, for both assertion and deassertion.
REQ-016 Core k's reset SHALL therefore fall RST_PIPE_DEPTH+k*STAGGER_CYCLES cycles after the first RELEASE cycle.
REQ-017 i_core_done SHALL be registered once, as done_r.
REQ-018 o_done_mask[k] SHALL set the cycle after done_r[k]=1 while o_core_reset[k]=0; done from a core held in reset is ignored.
REQ-019 o_done_all SHALL be a register of &o_done_mask, so it rises 2 cycles after the edge that sampled the last done.
REQ-020 Entry to HOLD or LOCK_WAIT SHALL clear o_done_mask and o_done_all.
REQ-021 o_run_cycles SHALL clear on LOCK_WAIT entry and increment every RELEASE and RUN cycle.
REQ-022 o_run_cycles SHALL saturate at all-ones and freeze in DONE and HOLD.

Reset
REQ-023 While rst_int=1: o_core_reset all ones, with every pipeline flop preset asynchronously so no clock is needed; o_done_mask=0; o_done_all=0; o_run_cycles=0; o_state=HOLD.
REQ-024 Reset asserted mid-operation SHALL set o_core_reset to all ones within the same cycle, with no waiting for the pipeline.

Verification (defaults unless noted)
REQ-025 reset release, i_locked=1 -> LOCK_WAIT within 3 cycles; RELEASE 16 cycles later; o_core_reset[0..3] fall at RELEASE+6/10/14/18; RUN at RELEASE+12.
REQ-026 done pulses on cores 2,0,3,1, last sampled at edge t -> mask 0xF at t+1; o_done_all=1 at t+2; state DONE; o_run_cycles frozen.
REQ-027 pulse i_core_done[3] while o_core_reset[3]=1 -> o_done_mask[3] stays 0.
REQ-028 drop i_locked in RUN -> HOLD within 3 cycles; o_core_reset all ones 6 cycles later; mask cleared; on relock, full sequence repeats.
REQ-029 i_restart in DONE -> LOCK_WAIT; o_run_cycles=0; mask=0; restart coincident with lock loss -> HOLD.
REQ-030 CNT_WIDTH=4, STAGGER_CYCLES=0, no done -> o_run_cycles holds 15; all resets fall together at RELEASE+6; async reset mid-RELEASE -> o_core_reset=0xF with clk stopped.
